// File: rtl/xadc_pkg.sv
// Shared XADC DRP definitions: aux channel addresses, config/error register addresses,
// responder FSM states and small address-decode helpers.
package xadc_pkg;

  typedef enum logic [6:0] {
    XA1 = 7'h16,
    XA2 = 7'h17,
    XA3 = 7'h1E,
    XA4 = 7'h1F
  } port_t;

  localparam logic [6:0] CFG0_ADDR = 7'h40;
  localparam logic [6:0] CFG1_ADDR = 7'h41;
  localparam logic [6:0] CFG2_ADDR = 7'h42;
  localparam logic [6:0] ERR_ADDR  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drp_state_t;

  function automatic logic is_sample_addr(input logic [6:0] addr);
    logic hit;
    case (addr)
      XA1, XA2, XA3, XA4: hit = 1'b1;
      default:            hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] sample_idx(input logic [6:0] addr);
    logic [1:0] idx;
    case (addr)
      XA1:     idx = 2'd0;
      XA2:     idx = 2'd1;
      XA3:     idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/drp_reg_bank.sv
// Storage for the four aux-channel sample registers and the three config registers,
// with a combinational read mux and write decode for both the DRP and sample sides.
module drp_reg_bank
  import xadc_pkg::*;
#(
  parameter logic [15:0] CFG0_RST = 16'h0000,
  parameter logic [15:0] CFG1_RST = 16'h2000,
  parameter logic [15:0] CFG2_RST = 16'h0400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        smp_we,
  input  logic [6:0]  smp_addr,
  input  logic [15:0] smp_wdata
);

  logic [15:0] smp_q [4];
  logic [15:0] smp_d [4];
  logic [15:0] cfg_q [3];
  logic [15:0] cfg_d [3];

  // Next-state for sample and config storage.
  always_comb begin
    smp_d = smp_q;
    cfg_d = cfg_q;
    if (smp_we && is_sample_addr(smp_addr)) begin
      smp_d[sample_idx(smp_addr)] = smp_wdata;
    end else begin
      smp_d = smp_q;
    end
    if (cfg_we) begin
      case (cfg_addr)
        CFG0_ADDR: cfg_d[0] = cfg_wdata;
        CFG1_ADDR: cfg_d[1] = cfg_wdata;
        CFG2_ADDR: cfg_d[2] = cfg_wdata;
        default:   cfg_d = cfg_q;
      endcase
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '{default: 16'h0000};
      cfg_q[0] <= CFG0_RST;
      cfg_q[1] <= CFG1_RST;
      cfg_q[2] <= CFG2_RST;
    end else begin
      smp_q <= smp_d;
      cfg_q <= cfg_d;
    end
  end

  // Read mux; a same-cycle sample write is not yet visible here.
  always_comb begin
    case (rd_addr)
      XA1:       rd_data = smp_q[0];
      XA2:       rd_data = smp_q[1];
      XA3:       rd_data = smp_q[2];
      XA4:       rd_data = smp_q[3];
      CFG0_ADDR: rd_data = cfg_q[0];
      CFG1_ADDR: rd_data = cfg_q[1];
      CFG2_ADDR: rd_data = cfg_q[2];
      default:   rd_data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/drp_sample_responder.sv
// XADC DRP slave stand-in: answers den/dwe/daddr with do/drdy after RD_LATENCY cycles.
// Optional macro DRP_PROTOCOL_CHECK_EN adds a den-while-busy counter at 0x7F and proto_err_out.
module drp_sample_responder
  import xadc_pkg::*;
#(
  parameter int          RD_LATENCY = 2,
  parameter logic [15:0] CFG0_RST   = 16'h0000,
  parameter logic [15:0] CFG1_RST   = 16'h2000,
  parameter logic [15:0] CFG2_RST   = 16'h0400
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  input  logic        smp_wr,
  input  logic [6:0]  smp_addr,
  input  logic [15:0] smp_data,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  output logic        busy_out,
  output logic        proto_err_out
);

  localparam logic [3:0] RD_LAT_M1 = 4'(RD_LATENCY - 1);

  drp_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] di_q, di_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] do_q, do_d;
  logic        drdy_q, drdy_d;
  logic        busy_q, busy_d;
  logic        eoc_q, eoc_d;
  logic [4:0]  chan_q, chan_d;
  logic [15:0] bank_rdata_s;
  logic [15:0] rd_mux_s;
  logic        cfg_we_s;
  logic        smp_hit_s;

  assign cfg_we_s  = (state_q == RESP) && wr_q;
  assign smp_hit_s = smp_wr && is_sample_addr(smp_addr);

  drp_reg_bank #(
    .CFG0_RST(CFG0_RST),
    .CFG1_RST(CFG1_RST),
    .CFG2_RST(CFG2_RST)
  ) u_bank (
    .clk      (clk_100MHz),
    .rst_n    (rst_n),
    .rd_addr  (daddr_in),
    .rd_data  (bank_rdata_s),
    .cfg_we   (cfg_we_s),
    .cfg_addr (addr_q),
    .cfg_wdata(di_q),
    .smp_we   (smp_wr),
    .smp_addr (smp_addr),
    .smp_wdata(smp_data)
  );

  // Request FSM next-state; read data is captured in the accept cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (den_in) begin
          addr_d  = daddr_in;
          wr_d    = dwe_in;
          di_d    = di_in;
          rdata_d = rd_mux_s;
          cnt_d   = 4'd1;
          state_d = (RD_LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == RD_LAT_M1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    drdy_d = (state_d == RESP);
    do_d   = drdy_d ? rdata_d : 16'h0000;
    busy_d = (state_d != IDLE);
    eoc_d  = smp_hit_s;
    chan_d = smp_hit_s ? smp_addr[4:0] : chan_q;
  end

  // FSM, transaction latches and registered outputs.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 7'h00;
      wr_q    <= 1'b0;
      di_q    <= 16'h0000;
      rdata_q <= 16'h0000;
      do_q    <= 16'h0000;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      chan_q  <= 5'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      do_q    <= do_d;
      drdy_q  <= drdy_d;
      busy_q  <= busy_d;
      eoc_q   <= eoc_d;
      chan_q  <= chan_d;
    end
  end

  assign do_out      = do_q;
  assign drdy_out    = drdy_q;
  assign busy_out    = busy_q;
  assign eoc_out     = eoc_q;
  assign channel_out = chan_q;

`ifdef DRP_PROTOCOL_CHECK_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       perr_q, perr_d;
  logic       viol_s, clr_s;

  assign viol_s   = den_in && (state_q != IDLE);
  assign clr_s    = cfg_we_s && (addr_q == ERR_ADDR);
  assign rd_mux_s = (daddr_in == ERR_ADDR) ? {8'h00, err_cnt_q} : bank_rdata_s;

  // Saturating violation counter; a clearing write wins over a coincident violation.
  always_comb begin
    err_cnt_d = err_cnt_q;
    perr_d    = perr_q;
    if (clr_s) begin
      err_cnt_d = 8'h00;
      perr_d    = 1'b0;
    end else if (viol_s) begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      perr_d    = 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Protocol-check registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
      perr_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      perr_q    <= perr_d;
    end
  end

  assign proto_err_out = perr_q;
`else
  assign rd_mux_s      = bank_rdata_s;
  assign proto_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_drp_sample_responder.sv
// Self-checking bench for drp_sample_responder: directed literal checks plus a randomized phase,
// all checked every cycle against a transaction-level reference model.
module tb_drp_sample_responder;

  localparam int LAT = 2;
`ifdef DRP_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_100MHz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [6:0]  daddr_in   = 7'h00;
  logic        den_in     = 1'b0;
  logic        dwe_in     = 1'b0;
  logic [15:0] di_in      = 16'h0000;
  logic        smp_wr     = 1'b0;
  logic [6:0]  smp_addr   = 7'h00;
  logic [15:0] smp_data   = 16'h0000;
  logic [15:0] do_out;
  logic        drdy_out;
  logic        eoc_out;
  logic [4:0]  channel_out;
  logic        busy_out;
  logic        proto_err_out;

  drp_sample_responder #(.RD_LATENCY(LAT)) dut (
    .clk_100MHz   (clk_100MHz),
    .rst_n        (rst_n),
    .daddr_in     (daddr_in),
    .den_in       (den_in),
    .dwe_in       (dwe_in),
    .di_in        (di_in),
    .do_out       (do_out),
    .drdy_out     (drdy_out),
    .smp_wr       (smp_wr),
    .smp_addr     (smp_addr),
    .smp_data     (smp_data),
    .eoc_out      (eoc_out),
    .channel_out  (channel_out),
    .busy_out     (busy_out),
    .proto_err_out(proto_err_out)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [15:0] m_smp [4];
  logic [15:0] m_cfg [3];
  int          m_err;
  bit          m_perr;
  bit          p_val;
  longint      p_due;
  logic [15:0] p_data;
  logic [6:0]  p_addr;
  bit          p_wr;
  logic [15:0] p_di;
  longint      cyc;
  logic [15:0] exp_do;
  bit          exp_drdy, exp_busy, exp_eoc;
  logic [4:0]  exp_chan;

  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'h16: return m_smp[0];
      7'h17: return m_smp[1];
      7'h1E: return m_smp[2];
      7'h1F: return m_smp[3];
      7'h40: return m_cfg[0];
      7'h41: return m_cfg[1];
      7'h42: return m_cfg[2];
      7'h7F: return CHK ? {8'h00, 8'(m_err)} : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int smp_index(input logic [6:0] a);
    case (a)
      7'h16: return 0;
      7'h17: return 1;
      7'h1E: return 2;
      7'h1F: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_smp = '{default: 16'h0000};
    m_cfg[0] = 16'h0000; m_cfg[1] = 16'h2000; m_cfg[2] = 16'h0400;
    m_err = 0; m_perr = 0; p_val = 0; cyc = 0;
    exp_do = 16'h0000; exp_drdy = 0; exp_busy = 0; exp_eoc = 0; exp_chan = 5'h00;
  endtask

  task automatic model_step();
    bit busy_c, clr, viol;
    int si;
    busy_c = p_val; clr = 0; viol = 0;
    if (p_val && p_due == cyc) begin
      if (p_wr) begin
        if (p_addr >= 7'h40 && p_addr <= 7'h42) m_cfg[p_addr - 7'h40] = p_di;
        if (p_addr == 7'h7F && CHK) clr = 1;
      end
      p_val = 0;
    end
    if (den_in) begin
      if (!busy_c) begin
        p_val = 1; p_due = cyc + LAT; p_data = m_read(daddr_in);
        p_addr = daddr_in; p_wr = dwe_in; p_di = di_in;
      end else begin
        viol = CHK;
      end
    end
    if (clr) begin
      m_err = 0; m_perr = 0;
    end else if (viol) begin
      m_err = (m_err < 255) ? m_err + 1 : 255; m_perr = 1;
    end
    si = smp_index(smp_addr);
    exp_eoc = smp_wr && si >= 0;
    if (exp_eoc) begin
      m_smp[si] = smp_data;
      exp_chan = smp_addr[4:0];
    end
    cyc++;
    exp_drdy = p_val && p_due == cyc;
    exp_do   = exp_drdy ? p_data : 16'h0000;
    exp_busy = p_val;
  endtask

  always @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk_100MHz) begin
    chk("drdy", drdy_out, exp_drdy);
    chk("do", do_out, exp_do);
    chk("busy", busy_out, exp_busy);
    chk("eoc", eoc_out, exp_eoc);
    chk("channel", channel_out, exp_chan);
    chk("proto_err", proto_err_out, m_perr);
  end

  // ---------------- directed helpers (called at a negedge) ----------------
  task automatic drp_xfer(input logic [6:0] a, input logic we, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
    den_in = 1'b1; daddr_in = a; dwe_in = we; di_in = d;
    @(negedge clk_100MHz);
    den_in = 1'b0; dwe_in = 1'b0; smp_wr = 1'b0; lat = 1;
    while (!drdy_out && lat < 20) begin
      @(negedge clk_100MHz);
      lat++;
    end
    if (!drdy_out) chk("drdy_timeout", 32'd0, 32'd1);
    rd = do_out;
    @(negedge clk_100MHz);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [15:0] exp);
    logic [15:0] rd;
    int lat;
    drp_xfer(a, 1'b0, 16'h0000, rd, lat);
    chk({name, "_data"}, rd, exp);
    chk({name, "_lat"}, lat, LAT);
  endtask

  task automatic wr_drp(input logic [6:0] a, input logic [15:0] d);
    logic [15:0] rd;
    int lat;
    drp_xfer(a, 1'b1, d, rd, lat);
    chk("wr_lat", lat, LAT);
  endtask

  task automatic smp_put(input logic [6:0] a, input logic [15:0] d);
    smp_wr = 1'b1; smp_addr = a; smp_data = d;
    @(negedge clk_100MHz);
    smp_wr = 1'b0;
  endtask

  int ndrdy;
  logic [6:0] addr_pool [9];

  initial begin
    addr_pool = '{7'h16, 7'h17, 7'h1E, 7'h1F, 7'h40, 7'h41, 7'h42, 7'h7F, 7'h05};
    repeat (3) @(negedge clk_100MHz);
    chk("rst_do", do_out, 16'h0000);
    chk("rst_drdy", drdy_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_chan", channel_out, 5'h00);
    rst_n = 1'b1;
    @(negedge clk_100MHz);

    // Sample write to XA2, eoc pulses exactly once, then read back.
    smp_put(7'h17, 16'hABC0);
    chk("eoc_pulse", eoc_out, 1'b1);
    chk("eoc_chan", channel_out, 5'h17);
    @(negedge clk_100MHz);
    chk("eoc_once", eoc_out, 1'b0);
    rd_chk("rd_xa2", 7'h17, 16'hABC0);

    // Config reset values and unmapped read.
    rd_chk("rd_cfg0", 7'h40, 16'h0000);
    rd_chk("rd_cfg2", 7'h42, 16'h0400);
    rd_chk("rd_unmapped", 7'h05, 16'h0000);

    // Config write/readback; write to sample reg is dropped.
    wr_drp(7'h41, 16'h1234);
    rd_chk("rd_cfg1", 7'h41, 16'h1234);
    smp_put(7'h16, 16'h7770);
    wr_drp(7'h16, 16'hFFFF);
    rd_chk("rd_xa1_ro", 7'h16, 16'h7770);

    // Same-cycle sample write and read of XA4.
    smp_put(7'h1F, 16'h1110);
    smp_wr = 1'b1; smp_addr = 7'h1F; smp_data = 16'h5550;
    rd_chk("rd_xa4_old", 7'h1F, 16'h1110);
    rd_chk("rd_xa4_new", 7'h1F, 16'h5550);

    // den while busy: exactly one drdy.
    ndrdy = 0;
    den_in = 1'b1; daddr_in = 7'h40; dwe_in = 1'b0;
    @(negedge clk_100MHz);
    ndrdy += int'(drdy_out);
    daddr_in = 7'h41;
    @(negedge clk_100MHz);
    den_in = 1'b0;
    ndrdy += int'(drdy_out);
    repeat (8) begin
      @(negedge clk_100MHz);
      ndrdy += int'(drdy_out);
    end
    chk("busy_one_drdy", ndrdy, 1);
    chk("proto_err_set", proto_err_out, CHK);
    rd_chk("rd_errcnt", 7'h7F, CHK ? 16'h0001 : 16'h0000);

    // Reset while waiting: no drdy during or after.
    den_in = 1'b1; daddr_in = 7'h41; dwe_in = 1'b0;
    @(negedge clk_100MHz);
    den_in = 1'b0;
    #2 rst_n = 1'b0;
    ndrdy = 0;
    repeat (3) begin
      @(negedge clk_100MHz);
      ndrdy += int'(drdy_out);
    end
    #2 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk_100MHz);
      ndrdy += int'(drdy_out);
    end
    chk("rst_abort_drdy", ndrdy, 0);
    chk("rst_proto_err", proto_err_out, 1'b0);
    rd_chk("rd_cfg1_rst", 7'h41, 16'h2000);

    // Randomized phase, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      den_in   = ($urandom_range(0, 2) == 0);
      daddr_in = ($urandom_range(0, 3) == 0) ? 7'($urandom) : addr_pool[$urandom_range(0, 8)];
      dwe_in   = $urandom_range(0, 1) == 1;
      di_in    = 16'($urandom);
      smp_wr   = $urandom_range(0, 1) == 1;
      smp_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : addr_pool[$urandom_range(0, 3)];
      smp_data = 16'($urandom);
      @(negedge clk_100MHz);
    end
    den_in = 1'b0; smp_wr = 1'b0;
    repeat (5) @(negedge clk_100MHz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
